cp0: RTL and testbench

Coprocessor-0 status/exception block for the pipelined MIPS core. It holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against exceptions collected down the pipe, and raises the flush/redirect request. It sits at the M/W boundary beside data memory: it consumes the W-stage `exlclr` (eret) and serves `mfc0` read data into the W-stage write-back mux.

---
 rtl/cp0_if.sv | 26 ++
 rtl/cp0.sv | 120 ++++++++++++
 tb/tb_cp0.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cp0_if.sv
// Coprocessor-0 pipeline-side bus: mtc0/mfc0 access, exception collection and
// the flush/redirect outputs. Master is the pipeline, slave is cp0.
interface cp0_if;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic [4:0]  exccode;
  logic        bd;
  logic        exlclr;
  logic [5:0]  hwint;
  logic        intreq;
  logic [31:0] epc;
  logic [31:0] dout;

  modport master (
    output a1, a2, din, we, pc, exccode, bd, exlclr, hwint,
    input  intreq, epc, dout
  );

  modport slave (
    input  a1, a2, din, we, pc, exccode, bd, exlclr, hwint,
    output intreq, epc, dout
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0 SR/Cause/EPC/PRId with interrupt/exception arbitration.
// Optional macro CP0_BD_EN: delay-slot aware EPC and Cause.BD.
module cp0 #(
  parameter logic [31:0] PRID = 32'h5A5A_2017
) (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;

  logic        irq_s;
  logic        exc_s;
  logic        intreq_s;
  logic [31:0] pc_align_s;
  logic [31:0] sr_s;
  logic [31:0] cause_s;
  logic [31:0] dout_s;
  logic        unused_s;

  assign irq_s      = ie_q & ~exl_q & (|(bus.hwint & im_q));
  assign exc_s      = ~exl_q & (bus.exccode != 5'd0);
  assign intreq_s   = irq_s | exc_s;
  assign pc_align_s = {bus.pc[31:2], 2'b00};

  assign sr_s    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
  assign cause_s = {bd_q, 15'h0000, ip_q, 3'b000, exc_q, 2'b00};

`ifdef CP0_BD_EN
  assign unused_s = ^{bus.pc[1:0], bus.din[31:16], bus.din[9:2]};
`else
  assign unused_s = ^{bus.pc[1:0], bus.din[31:16], bus.din[9:2], bus.bd};
`endif

  // Next-state: exception entry overrides mtc0/eret for that cycle
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    exc_d = exc_q;
    bd_d  = bd_q;
    epc_d = epc_q;
    if (intreq_s) begin
      exl_d = 1'b1;
      exc_d = irq_s ? 5'd0 : bus.exccode;
`ifdef CP0_BD_EN
      bd_d  = bus.bd;
      epc_d = bus.bd ? (pc_align_s - 32'd4) : pc_align_s;
`else
      bd_d  = 1'b0;
      epc_d = pc_align_s;
`endif
    end else begin
      if (bus.we) begin
        case (bus.a2)
          5'd12: begin
            im_d  = bus.din[15:10];
            exl_d = bus.din[1];
            ie_d  = bus.din[0];
          end
          5'd14: epc_d = {bus.din[31:2], 2'b00};
          default: epc_d = epc_q;
        endcase
      end else begin
        epc_d = epc_q;
      end
      // eret is applied after a coincident SR write
      if (bus.exlclr) begin
        exl_d = 1'b0;
      end else begin
        exl_d = exl_d;
      end
    end
  end

  // State registers; Cause.IP samples the raw interrupt lines every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= 6'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      ip_q  <= 6'd0;
      exc_q <= 5'd0;
      bd_q  <= 1'b0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      ip_q  <= bus.hwint;
      exc_q <= exc_d;
      bd_q  <= bd_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux
  always_comb begin
    dout_s = 32'd0;
    case (bus.a1)
      5'd12:   dout_s = sr_s;
      5'd13:   dout_s = cause_s;
      5'd14:   dout_s = epc_q;
      5'd15:   dout_s = PRID;
      default: dout_s = 32'd0;
    endcase
  end

  assign bus.intreq = intreq_s;
  assign bus.epc    = epc_q;
  assign bus.dout   = dout_s;

endmodule

// File: tb/tb_cp0.sv
// Directed table-driven bench for cp0 plus hand sequences for async reset
// and the IE-enable-with-pending-interrupt corner.
module tb_cp0;

  logic clk;
  logic reset;
  cp0_if bus ();

  cp0 #(.PRID(32'h5A5A_2017)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CP0_BD_EN
  localparam logic [31:0] BD_EPC   = 32'h0000_3020;
  localparam logic [31:0] BD_CAUSE = 32'h8000_0028;
`else
  localparam logic [31:0] BD_EPC   = 32'h0000_3024;
  localparam logic [31:0] BD_CAUSE = 32'h0000_0028;
`endif
  localparam logic [31:0] PRID_V = 32'h5A5A_2017;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic [4:0]  exccode;
    logic        bd;
    logic        exlclr;
    logic [5:0]  hwint;
    logic        exp_intreq;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
    input logic we, input logic [31:0] pc, input logic [4:0] exccode,
    input logic bd, input logic exlclr, input logic [5:0] hwint,
    input logic ei, input logic [31:0] ed, input logic [31:0] ee);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc;
    v.exccode = exccode; v.bd = bd; v.exlclr = exlclr; v.hwint = hwint;
    v.exp_intreq = ei; v.exp_dout = ed; v.exp_epc = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.a1 = 5'd0; bus.a2 = 5'd0; bus.din = 32'd0; bus.we = 1'b0;
    bus.pc = 32'd0; bus.exccode = 5'd0; bus.bd = 1'b0;
    bus.exlclr = 1'b0; bus.hwint = 6'd0;
  endtask

  initial begin
    //            a1     a2     din            we    pc             exc    bd    clr   hwint      intreq dout           epc
    vecs[0]  = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_0000, 32'h0000_0000);
    vecs[1]  = mk(5'd15, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, PRID_V,        32'h0000_0000);
    vecs[2]  = mk(5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_0000, 32'h0000_0000);
    vecs[3]  = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'h0000_3010, 5'd0,  1'b0, 1'b0, 6'b000100, 1'b1, 32'h0000_FC01, 32'h0000_0000);
    vecs[4]  = mk(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000100, 1'b0, 32'h0000_3010, 32'h0000_3010);
    vecs[5]  = mk(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000100, 1'b0, 32'h0000_1000, 32'h0000_3010);
    vecs[6]  = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000100, 1'b0, 32'h0000_FC03, 32'h0000_3010);
    vecs[7]  = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b1, 6'b000100, 1'b0, 32'h0000_FC03, 32'h0000_3010);
    vecs[8]  = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'h0000_3040, 5'd0,  1'b0, 1'b0, 6'b000100, 1'b1, 32'h0000_FC01, 32'h0000_3010);
    vecs[9]  = mk(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b1, 6'b000000, 1'b0, 32'h0000_3040, 32'h0000_3040);
    vecs[10] = mk(5'd12, 5'd12, 32'h0000_FC00, 1'b1, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_FC01, 32'h0000_3040);
    vecs[11] = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'h0000_3060, 5'd4,  1'b0, 1'b0, 6'b000001, 1'b1, 32'h0000_FC00, 32'h0000_3040);
    vecs[12] = mk(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,         5'd4,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_0410, 32'h0000_3060);
    vecs[13] = mk(5'd12, 5'd12, 32'h0000_FC03, 1'b1, 32'd0,         5'd0,  1'b0, 1'b1, 6'b000000, 1'b0, 32'h0000_FC02, 32'h0000_3060);
    vecs[14] = mk(5'd12, 5'd14, 32'hFFFF_FFFF, 1'b1, 32'h0000_3070, 5'd12, 1'b0, 1'b1, 6'b000010, 1'b1, 32'h0000_FC01, 32'h0000_3060);
    vecs[15] = mk(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_0800, 32'h0000_3070);
    vecs[16] = mk(5'd12, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_FC03, 32'h0000_3070);
    vecs[17] = mk(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b1, 6'b000000, 1'b0, 32'h0000_3070, 32'h0000_3070);
    vecs[18] = mk(5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_0000, 32'h0000_3070);
    vecs[19] = mk(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_0000, 32'h0000_3070);
    vecs[20] = mk(5'd14, 5'd14, 32'h0000_3107, 1'b1, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_3070, 32'h0000_3070);
    vecs[21] = mk(5'd14, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, 32'h0000_3104, 32'h0000_3104);
    vecs[22] = mk(5'd15, 5'd15, 32'h0000_0000, 1'b1, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, PRID_V,        32'h0000_3104);
    vecs[23] = mk(5'd13, 5'd0,  32'd0,         1'b0, 32'h0000_3024, 5'd10, 1'b1, 1'b0, 6'b000000, 1'b1, 32'h0000_0000, 32'h0000_3104);
    vecs[24] = mk(5'd13, 5'd0,  32'd0,         1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 6'b000000, 1'b0, BD_CAUSE,      BD_EPC);
    vecs[25] = mk(5'd14, 5'd0,  32'd0,         1'b0, 32'h0000_3090, 5'd10, 1'b0, 1'b0, 6'b000000, 1'b0, BD_EPC,        BD_EPC);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.a1 = vecs[i].a1; bus.a2 = vecs[i].a2; bus.din = vecs[i].din;
      bus.we = vecs[i].we; bus.pc = vecs[i].pc; bus.exccode = vecs[i].exccode;
      bus.bd = vecs[i].bd; bus.exlclr = vecs[i].exlclr; bus.hwint = vecs[i].hwint;
      #1;
      check($sformatf("v%0d_intreq", i), {31'd0, bus.intreq}, {31'd0, vecs[i].exp_intreq});
      check($sformatf("v%0d_dout", i), bus.dout, vecs[i].exp_dout);
      check($sformatf("v%0d_epc", i), bus.epc, vecs[i].exp_epc);
    end

    // Asynchronous reset in the middle of a handler (EXL=1, EPC nonzero)
    @(negedge clk);
    drive_idle();
    bus.a1 = 5'd12;
    bus.hwint = 6'b000100;
    #1;
    check("pre_reset_sr_exl", bus.dout & 32'h0000_0002, 32'h0000_0002);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_intreq", {31'd0, bus.intreq}, 32'd0);
    check("async_rst_epc", bus.epc, 32'd0);
    check("async_rst_sr", bus.dout, 32'd0);
    bus.a1 = 5'd13;
    #0.5;
    check("async_rst_cause", bus.dout, 32'd0);
    bus.a1 = 5'd15;
    #0.5;
    check("async_rst_prid", bus.dout, PRID_V);
    @(negedge clk);
    reset = 1'b0;

    // mtc0 enabling IE with an interrupt already pending
    @(negedge clk);
    bus.a1 = 5'd12; bus.a2 = 5'd12; bus.we = 1'b1;
    bus.din = 32'h0000_0401; bus.hwint = 6'b000001; bus.pc = 32'h0000_3080;
    #1;
    check("ie_set_intreq_same", {31'd0, bus.intreq}, 32'd0);
    check("ie_set_read_old", bus.dout, 32'd0);
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    check("ie_set_intreq_next", {31'd0, bus.intreq}, 32'd1);
    @(negedge clk);
    #1;
    check("ie_set_intreq_drop", {31'd0, bus.intreq}, 32'd0);
    check("ie_set_epc", bus.epc, 32'h0000_3080);
    check("ie_set_sr", bus.dout, 32'h0000_0403);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
